// File: rtl/alu_pkg.sv
// Shared ALU opcodes and arbiter FSM encoding for the Execute-stage ALU arbiter.
package alu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_SLTU = 3'b100
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        EXEC = ST_EXEC,
        RESP = ST_RESP
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU (ADD/SUB/AND/OR/SLTU, unknown opcodes add) with an optional output register.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 3,
    parameter int REG_OUTPUT = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [SEL_WIDTH-1:0]  i_sel,
    output logic [DATA_WIDTH-1:0] o_result
);

    logic [DATA_WIDTH-1:0] result_next;

    always_comb begin
        case (i_sel)
            SEL_WIDTH'(ALU_SUB):  result_next = i_a - i_b;
            SEL_WIDTH'(ALU_AND):  result_next = i_a & i_b;
            SEL_WIDTH'(ALU_OR):   result_next = i_a | i_b;
            SEL_WIDTH'(ALU_SLTU): result_next = {{(DATA_WIDTH-1){1'b0}}, (i_a < i_b)};
            default:              result_next = i_a + i_b;
        endcase
    end

    generate
        if (REG_OUTPUT != 0) begin : g_reg_out
            logic [DATA_WIDTH-1:0] result_reg;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    result_reg <= '0;
                end else begin
                    result_reg <= result_next;
                end
            end

            assign o_result = result_reg;
        end else begin : g_comb_out
            logic unused_clk_rst;

            assign unused_clk_rst = i_clk ^ i_rst_n;
            assign o_result       = result_next;
        end
    endgenerate

endmodule

// File: rtl/alu_arb_grant.sv
// Grant selection for the ALU arbiter: round-robin by default, lowest index wins
// when ALU_ARB_FIXED_PRIO_EN is defined (no pointer state in that build).
module alu_arb_grant #(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic               i_grant_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id,
    output logic               o_accept
);

    // cand_id[j] is the requester examined at search position j
    logic [ID_W-1:0] cand_id [NUM_REQ];
    logic [ID_W-1:0] grant_id;
    logic            grant_any;

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_clk_rst;

    assign unused_clk_rst = i_clk ^ i_rst_n;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_id[gi] = ID_W'(gi);
        end
    endgenerate
`else
    logic [ID_W-1:0] ptr_reg;
    logic [ID_W-1:0] ptr_next;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [ID_W:0] sum;

            assign sum         = {1'b0, ptr_reg} + (ID_W+1)'(gi);
            assign cand_id[gi] = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                                                             : sum[ID_W-1:0];
        end
    endgenerate

    always_comb begin
        ptr_next = ptr_reg;
        if (o_accept) begin
            ptr_next = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`endif

    // Walk from the back so the earliest valid search position wins
    always_comb begin
        grant_id  = '0;
        grant_any = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (i_req_valid[cand_id[j]]) begin
                grant_id  = cand_id[j];
                grant_any = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign o_grant[gi] = i_grant_en & grant_any & (grant_id == ID_W'(gi));
        end
    endgenerate

    assign o_grant_id = grant_id;
    assign o_accept   = i_grant_en & grant_any;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters; one operation in flight, result returned tagged with ID.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int SEL_WIDTH  = 3,
    parameter  int NUM_REQ    = 2,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_src_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_src_b,
    input  logic [NUM_REQ*SEL_WIDTH-1:0]  i_req_sel,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    output logic [ID_W-1:0]               o_rsp_id
);

    arb_state_t            state_reg;
    arb_state_t            state_next;

    logic [DATA_WIDTH-1:0] op_a_reg;
    logic [DATA_WIDTH-1:0] op_b_reg;
    logic [SEL_WIDTH-1:0]  op_sel_reg;
    logic [ID_W-1:0]       op_id_reg;

    logic                  rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_data_reg;
    logic [ID_W-1:0]       rsp_id_reg;

    logic                  grant_en;
    logic                  accept;
    logic [NUM_REQ-1:0]    grant_vec;
    logic [ID_W-1:0]       grant_id;
    logic [DATA_WIDTH-1:0] alu_result;

    logic [DATA_WIDTH-1:0] src_a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] src_b_arr [NUM_REQ];
    logic [SEL_WIDTH-1:0]  sel_arr   [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign src_a_arr[gi] = i_req_src_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign src_b_arr[gi] = i_req_src_b[gi*DATA_WIDTH +: DATA_WIDTH];
            assign sel_arr[gi]   = i_req_sel[gi*SEL_WIDTH +: SEL_WIDTH];
        end
    endgenerate

    // Reset gating keeps ready low while reset is held even if requesters are valid
    assign grant_en = i_rst_n & ((state_reg == IDLE) | ((state_reg == RESP) & i_rsp_ready));

    alu_arb_grant #(
        .NUM_REQ (NUM_REQ)
    ) u_grant (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .i_grant_en  (grant_en),
        .o_grant     (grant_vec),
        .o_grant_id  (grant_id),
        .o_accept    (accept)
    );

    alu #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH),
        .REG_OUTPUT (0)
    ) u_alu (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_a      (op_a_reg),
        .i_b      (op_b_reg),
        .i_sel    (op_sel_reg),
        .o_result (alu_result)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (i_rsp_ready) begin
                    state_next = accept ? EXEC : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= IDLE;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            op_sel_reg    <= '0;
            op_id_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_id_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_a_reg   <= src_a_arr[grant_id];
                op_b_reg   <= src_b_arr[grant_id];
                op_sel_reg <= sel_arr[grant_id];
                op_id_reg  <= grant_id;
            end
            // Result is captured once at the end of EXEC and held through RESP
            if (state_reg == EXEC) begin
                rsp_valid_reg <= 1'b1;
                rsp_data_reg  <= alu_result;
                rsp_id_reg    <= op_id_reg;
            end else if ((state_reg == RESP) && i_rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign o_req_ready = grant_vec;
    assign o_rsp_valid = rsp_valid_reg;
    assign o_rsp_data  = rsp_data_reg;
    assign o_rsp_id    = rsp_id_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int SW = 3;
    localparam int NR = 2;
    localparam int IW = 1;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [NR-1:0]     i_req_valid;
    logic [NR-1:0]     o_req_ready;
    logic [NR*DW-1:0]  i_req_src_a;
    logic [NR*DW-1:0]  i_req_src_b;
    logic [NR*SW-1:0]  i_req_sel;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [DW-1:0]     o_rsp_data;
    logic [IW-1:0]     o_rsp_id;

    always #5 i_clk = ~i_clk;

    alu_arbiter #(
        .DATA_WIDTH (DW),
        .SEL_WIDTH  (SW),
        .NUM_REQ    (NR)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_src_a (i_req_src_a),
        .i_req_src_b (i_req_src_b),
        .i_req_sel   (i_req_sel),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_id    (o_rsp_id)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
    } op_t;

    op_t         dir_q[$];
    op_t         cur[NR];
    bit          present[NR];
    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;

    // Reference model: one op in flight, result visible two cycles after accept
    bit          m_inflight = 1'b0;
    int          m_vis      = 0;
    logic [31:0] m_data     = '0;
    int          m_id       = 0;
    int          m_ptr      = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input op_t op);
        case (op.sel)
            3'd1:    return op.a - op.b;
            3'd2:    return op.a & op.b;
            3'd3:    return op.a | op.b;
            3'd4:    return (op.a < op.b) ? 32'd1 : 32'd0;
            default: return op.a + op.b;
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic drive(input bit [NR-1:0] mask, input int p_present, input int p_ready);
        for (int k = 0; k < NR; k++) begin
            if (!present[k] && mask[k] && (int'($urandom_range(0, 99)) < p_present)) begin
                if (k == 0 && dir_q.size() > 0) begin
                    cur[k] = dir_q.pop_front();
                end else begin
                    cur[k] = '{a: rnd_val(), b: rnd_val(), sel: 3'($urandom_range(0, 7))};
                end
                present[k] = 1'b1;
            end
            i_req_valid[k]            = present[k];
            i_req_src_a[k*DW +: DW]   = cur[k].a;
            i_req_src_b[k*DW +: DW]   = cur[k].b;
            i_req_sel[k*SW +: SW]     = cur[k].sel;
        end
        i_rsp_ready = (int'($urandom_range(0, 99)) < p_ready);
    endtask

    task automatic check_and_update();
        bit            exp_valid;
        bit            eligible;
        bit            found;
        int            w;
        int            k;
        logic [NR-1:0] exp_ready;

        exp_valid = m_inflight && (cycle >= m_vis);
        check("rsp_valid", 64'(o_rsp_valid), 64'(exp_valid));
        if (exp_valid) begin
            check("rsp_data", 64'(o_rsp_data), 64'(m_data));
            check("rsp_id", 64'(o_rsp_id), 64'(m_id));
        end

        eligible = !m_inflight || (exp_valid && i_rsp_ready);
        found    = 1'b0;
        w        = 0;
        if (eligible) begin
            for (int j = 0; j < NR; j++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                k = j;
`else
                k = (m_ptr + j) % NR;
`endif
                if (!found && present[k]) begin
                    found = 1'b1;
                    w     = k;
                end
            end
        end
        exp_ready = '0;
        if (found) exp_ready[w] = 1'b1;
        check("req_ready", 64'(o_req_ready), 64'(exp_ready));

        if (exp_valid && i_rsp_ready) begin
            $display("rsp id=%0d data=%08h cycle=%0d", m_id, m_data, cycle);
            m_inflight = 1'b0;
        end
        if (found) begin
            m_inflight = 1'b1;
            m_vis      = cycle + 2;
            m_data     = ref_alu(cur[w]);
            m_id       = w;
            m_ptr      = (w + 1) % NR;
            present[w] = 1'b0;
        end
    endtask

    task automatic run_cycles(input bit [NR-1:0] mask, input int p_present, input int p_ready, input int n);
        for (int c = 0; c < n; c++) begin
            drive(mask, p_present, p_ready);
            #1;
            check_and_update();
            @(posedge i_clk);
            #1;
            cycle++;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, 64'(o_req_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'd0);
        check({tag, "_rsp_data"}, 64'(o_rsp_data), 64'd0);
        check({tag, "_rsp_id"}, 64'(o_rsp_id), 64'd0);
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        i_req_src_a = '0;
        i_req_src_b = '0;
        i_req_sel   = '0;
        i_rsp_ready = 1'b0;
        for (int k = 0; k < NR; k++) begin
            present[k] = 1'b0;
            cur[k]     = '0;
        end
        dir_q.push_back('{a: 32'd5,          b: 32'd7,          sel: 3'b000});
        dir_q.push_back('{a: 32'hFFFF_FFFF,  b: 32'd1,          sel: 3'b000});
        dir_q.push_back('{a: 32'd3,          b: 32'd5,          sel: 3'b001});
        dir_q.push_back('{a: 32'h0000_F0F0,  b: 32'h0000_0FF0,  sel: 3'b010});
        dir_q.push_back('{a: 32'h0000_F000,  b: 32'h0000_000F,  sel: 3'b011});
        dir_q.push_back('{a: 32'd1,          b: 32'hFFFF_FFFF,  sel: 3'b100});
        dir_q.push_back('{a: 32'd2,          b: 32'd3,          sel: 3'b111});

        // Reset with a requester already valid: ready must still be low
        present[0] = 1'b1;
        cur[0]     = '{a: 32'd9, b: 32'd9, sel: 3'b000};
        drive('0, 0, 100);
        @(posedge i_clk);
        #1;
        check_outputs_zero("reset");
        @(posedge i_clk);
        #1;
        present[0] = 1'b0;
        drive('0, 0, 100);
        i_rst_n = 1'b1;

        run_cycles(2'b01, 100, 100, 20);   // directed single-requester ops
        run_cycles(2'b11, 100, 100, 12);   // contention
        run_cycles(2'b11, 100, 100, 3);
        run_cycles(2'b11, 100, 0, 5);      // backpressure
        run_cycles(2'b11, 100, 100, 4);
        run_cycles(2'b11, 60, 70, 300);    // random traffic

        // Reset during EXEC after a grant to requester 0
        run_cycles(2'b00, 0, 100, 8);
        run_cycles(2'b01, 100, 100, 1);
        i_rst_n = 1'b0;
        #1;
        check_outputs_zero("midop_reset");
        m_inflight = 1'b0;
        m_ptr      = 0;
        for (int k = 0; k < NR; k++) present[k] = 1'b0;
        drive('0, 0, 100);
        @(posedge i_clk);
        #1;
        cycle++;
        i_rst_n = 1'b1;
        run_cycles(2'b11, 100, 100, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one ALU datapath between NUM_REQ independent requesters in the Execute stage, such as the main pipeline, the branch-target adder path and a debug/CSR unit. Grants are round-robin with valid/ready handshakes. The block latches the winner's operands and opcode, drives the internal combinational ALU, and registers the result. It returns the result on a single response channel tagged with the requester ID. One operation is in flight at a time.

## Interface
- DATA_WIDTH, 32, operand/result width
- SEL_WIDTH, 3, ALU opcode width
- NUM_REQ, 2, number of requesters (legal 2..4)
- ID_W, $clog2(NUM_REQ), requester ID width (derived, localparam)

- i_clk  in  1  clock; all logic rising-edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_req_valid  in  NUM_REQ  per-requester request valid
- o_req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- i_req_src_a  in  NUM_REQ*DATA_WIDTH  packed operand A; slice k belongs to requester k
- i_req_src_b  in  NUM_REQ*DATA_WIDTH  packed operand B
- i_req_sel  in  NUM_REQ*SEL_WIDTH  packed opcode
- o_rsp_valid  out  1  result valid
- i_rsp_ready  in  1  consumer accepts result
- o_rsp_data  out  DATA_WIDTH  ALU result
- o_rsp_id  out  ID_W  index of the requester that issued the operation

## Operation
- The FSM has three states.
  - IDLE: no operation held.
  - EXEC: operands are latched and the ALU evaluates.
  - RESP: the result is held.
- Transitions:
  - IDLE → EXEC on any accept.
  - EXEC → RESP unconditionally.
  - RESP → IDLE on i_rsp_ready with no pending request.
  - RESP → EXEC on i_rsp_ready with a pending request.
  - RESP otherwise stays in RESP.
- Grant is issued only in IDLE, or in RESP in a cycle where i_rsp_ready=1.
  - The winner k gets o_req_ready[k]=1.
  - Accept means i_req_valid[k] & o_req_ready[k].
- o_req_ready may depend combinationally on i_req_valid. Requesters must not gate valid on ready.
- Requesters hold valid, operands and opcode stable until accepted. Deasserting valid before accept is illegal.
- On accept, src_a, src_b, sel and ID are captured into operand registers.
- Round-robin:
  - The pointer resets to 0.
  - The search order is ptr, ptr+1, … mod NUM_REQ.
  - After a grant to k, ptr becomes (k+1) mod NUM_REQ.
  - The pointer updates only on accept.
- ALU opcodes:
  - 000 ADD.
  - 001 SUB.
  - 010 AND.
  - 011 OR.
  - 100 SLTU: unsigned a<b, result zero-extended to DATA_WIDTH.
  - 101–111 behave as ADD.
- Arithmetic wraps modulo 2^DATA_WIDTH. There are no carry or overflow outputs.
- o_rsp_data and o_rsp_id are loaded at the end of EXEC. They hold stable while o_rsp_valid=1 and i_rsp_ready=0.

## Timing
- Reset values:
  - State IDLE, ptr 0.
  - o_req_ready 0, o_rsp_valid 0, o_rsp_data 0, o_rsp_id 0.
  - Operand registers 0.
- Reset asserted mid-operation discards the held operation. No response is produced for it.
- Latency: accept in cycle N gives o_rsp_valid=1 in cycle N+2.
- Throughput is one operation per 2 cycles under continuous demand with i_rsp_ready=1.
- RESP with i_rsp_ready=1 and a pending request is a simultaneous event:
  - Response retire and new accept occur in the same cycle.
  - o_rsp_valid drops to 0 for exactly the EXEC cycle.
- Backpressure:
  - While in RESP with i_rsp_ready=0, all o_req_ready=0.
  - Requests wait; no request is dropped.
- A single active requester is granted every eligible cycle regardless of ptr.

## Configuration
- ALU_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, where the lowest index wins. ptr is not implemented.
  - Undefined (default): round-robin as above.
- All other behaviour and timing are identical in both builds.

## Structure
- The shared package alu_pkg holds:
  - The opcode enum: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLTU=3'b100.
  - The FSM state enum arb_state_t (IDLE, EXEC, RESP).
- Sub-module alu_arb_grant contains the grant vector computation and pointer update. It honours the macro.
- The top instantiates the existing ALU with REG_OUTPUT=0. Result registering belongs to the arbiter.

## Test plan
- Single op, 32-bit: requester 0 sends a=5, b=7, sel=000, i_rsp_ready=1.
  - Expect accept at N, o_rsp_valid at N+2, data=12, id=0.
- All opcodes:
  - 0xFFFFFFFF+1 gives 0.
  - 3−5 gives 0xFFFFFFFE.
  - 0xF0F0&0x0FF0 gives 0x00F0.
  - 0xF000|0x000F gives 0xF00F.
  - SLTU 1<0xFFFFFFFF gives 1.
  - sel=111 with a=2, b=3 gives 5.
- Contention: both requesters valid continuously with i_rsp_ready=1.
  - Expect IDs 0,1,0,1, each 2 cycles apart.
  - With ALU_ARB_FIXED_PRIO_EN defined, expect IDs 0,0,0.
- Backpressure: hold i_rsp_ready=0 for 5 cycles with requester 1 pending.
  - Expect data and id stable and o_req_ready=0.
  - On release, expect requester 1 accepted the same cycle.
- Reset mid-op: assert i_rst_n=0 in the EXEC cycle.
  - Expect all outputs 0 immediately and no response after release.
  - The next request is granted to requester 0 first.
